// File: rtl/lcd_text_writer.sv
// 4-bit HD44780-style LCD driver: power-up init, then rewrites both 16-character
// lines from a snapshot of strdata on each refresh request.
module lcd_text_writer #(
  parameter int POWERUP_CYC  = 750000,
  parameter int EN_PW_CYC    = 12,
  parameter int NIB_GAP_CYC  = 50,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLR_WAIT_CYC = 82000
) (
  input  logic         CCLK,
  input  logic         rst,
  input  logic         cls,
  input  logic [255:0] strdata,
  output logic         busy,
  output logic         LCDE,
  output logic         LCDRS,
  output logic         LCDRW,
  output logic [3:0]   LCDDAT
);

  localparam int MAX_A   = (POWERUP_CYC > CLR_WAIT_CYC) ? POWERUP_CYC : CLR_WAIT_CYC;
  localparam int MAX_B   = (CMD_WAIT_CYC > NIB_GAP_CYC) ? CMD_WAIT_CYC : NIB_GAP_CYC;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (MAX_C > EN_PW_CYC + 5) ? MAX_C : EN_PW_CYC + 5;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [5:0] LAST_INIT = 6'd7;
  localparam logic [5:0] LAST_REF  = 6'd33;

  typedef enum logic [2:0] {S_PWR, S_INIT, S_IDLE, S_LOAD, S_SEND, S_WAIT} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       idx;          // init item 0..7 or refresh byte 0..33
  logic             in_init;
  logic             low_phase;
  logic             pending;
  logic [255:0]     snap;

  logic [7:0]       init_byte, cur_char, cur_byte;
  logic [4:0]       ci;
  logic [3:0]       nib;
  logic             rs, single_nib, in_gap, send_done, cnt_done;
  logic [CNT_W-1:0] wait_last;

  assign LCDRW = 1'b0;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    init_byte = 8'h00;
    case (idx[2:0])
      3'd0, 3'd1, 3'd2: init_byte = 8'h03;
      3'd3:             init_byte = 8'h02;
      3'd4:             init_byte = 8'h28;
      3'd5:             init_byte = 8'h06;
      3'd6:             init_byte = 8'h0C;
      default:          init_byte = 8'h01;
    endcase

    // Refresh bytes 1..16 are characters 0..15, bytes 18..33 are characters 16..31.
    ci       = idx[4:0] - ((idx >= 6'd18) ? 5'd2 : 5'd1);
    cur_char = snap[{~ci, 3'b000} +: 8];

    if (in_init)           cur_byte = init_byte;
    else if (idx == 6'd0)  cur_byte = 8'h80;
    else if (idx == 6'd17) cur_byte = 8'hC0;
    else                   cur_byte = cur_char;

    single_nib = in_init && (idx < 6'd4);
    nib        = (single_nib || low_phase) ? cur_byte[3:0] : cur_byte[7:4];
    rs         = !in_init && (idx != 6'd0) && (idx != 6'd17);
    in_gap     = !single_nib && !low_phase;

    if (in_gap)
      wait_last = CNT_W'(NIB_GAP_CYC - 1);
    else if (in_init && (idx < 6'd4 || idx == LAST_INIT))
      wait_last = CNT_W'(CLR_WAIT_CYC - 1);
    else
      wait_last = CNT_W'(CMD_WAIT_CYC - 1);

    send_done = (cnt == CNT_W'(EN_PW_CYC + 4));
    cnt_done  = (cnt == wait_last);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_PWR:  if (cnt == CNT_W'(POWERUP_CYC - 1)) state_nx = S_INIT;
      S_INIT: state_nx = (idx > LAST_INIT) ? S_IDLE : S_SEND;
      S_IDLE: if (pending) state_nx = S_LOAD;
      S_LOAD: state_nx = S_SEND;
      S_SEND: if (send_done) state_nx = S_WAIT;
      S_WAIT: begin
        if (cnt_done) begin
          if (in_gap)               state_nx = S_SEND;
          else if (in_init)         state_nx = S_INIT;
          else if (idx == LAST_REF) state_nx = S_IDLE;
          else                      state_nx = S_SEND;
        end
      end
      default: state_nx = S_PWR;
    endcase
    busy = !(state == S_IDLE && !pending);
  end

  always_ff @(posedge CCLK) begin
    if (rst) state <= S_PWR;
    else     state <= state_nx;
  end

  // Strobe frame in S_SEND: cnt 0 loads the nibble, 1-2 setup, EN_PW_CYC high, then 2 hold.
  always_ff @(posedge CCLK) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      in_init   <= 1'b1;
      low_phase <= 1'b0;
      pending   <= 1'b0;
      LCDE      <= 1'b0;
      LCDRS     <= 1'b0;
      LCDDAT    <= 4'h0;
    end else begin
      if (cls)                            pending <= 1'b1;
      else if (state == S_IDLE && pending) pending <= 1'b0;

      if (state_nx != state)
        cnt <= '0;
      else if (state == S_PWR || state == S_SEND || state == S_WAIT)
        cnt <= cnt + CNT_W'(1);

      case (state)
        S_PWR: begin
          idx     <= '0;
          in_init <= 1'b1;
        end
        S_INIT: low_phase <= 1'b0;
        S_LOAD: begin
          idx       <= '0;
          in_init   <= 1'b0;
          low_phase <= 1'b0;
        end
        S_SEND: begin
          if (cnt == '0) begin
            LCDDAT <= nib;
            LCDRS  <= rs;
          end
          if (cnt == CNT_W'(2))             LCDE <= 1'b1;
          if (cnt == CNT_W'(EN_PW_CYC + 2)) LCDE <= 1'b0;
        end
        S_WAIT: begin
          if (cnt_done) begin
            if (in_gap) begin
              low_phase <= 1'b1;
            end else begin
              low_phase <= 1'b0;
              idx       <= idx + 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the snapshot is deliberately left out of reset; it is only read after S_LOAD fills it.
  always_ff @(posedge CCLK) begin
    if (state == S_LOAD) snap <= strdata;
  end

endmodule

// File: doc/lcd_text_writer.md
LCD_TEXT_WRITER -- requirements
Module: lcd_text_writer

Interface
REQ-001 SHALL have parameter POWERUP_CYC, default 750000, meaning the power-up wait of 15 ms at 50 MHz.
REQ-002 SHALL have parameter EN_PW_CYC, default 12, meaning the LCDE high time in cycles.
REQ-003 SHALL have parameter NIB_GAP_CYC, default 50, meaning the idle cycles between the two nibbles of a byte.
REQ-004 SHALL have parameter CMD_WAIT_CYC, default 2000, meaning the wait of 40 us after an ordinary byte.
REQ-005 SHALL have parameter CLR_WAIT_CYC, default 82000, meaning the wait after a clear and after each init nibble.
REQ-006 SHALL have port CCLK, input, 1 bit: the single clock; every flop is clocked on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port cls, input, 1 bit: refresh request, sampled every cycle.
REQ-009 SHALL have port strdata, input, 256 bits: 32 ASCII characters, bits [255:248] = line 1 column 0.
REQ-010 SHALL have port busy, output, 1 bit: high while in init or during a refresh.
REQ-011 SHALL have port LCDE, output, 1 bit: the LCD enable strobe.
REQ-012 SHALL have port LCDRS, output, 1 bit: the LCD register select (0 = command, 1 = data).
REQ-013 SHALL have port LCDRW, output, 1 bit: the LCD read/write line, constant 0.
REQ-014 SHALL have port LCDDAT, output, 4 bits: the LCD data nibble.

Function
REQ-015 SHALL use this FSM: S_PWR, S_INIT, S_IDLE, S_LOAD, S_SEND, S_WAIT.
REQ-016 S_PWR: SHALL count POWERUP_CYC cycles, then go to S_INIT.
REQ-017 S_INIT: SHALL send single nibbles 0x3, 0x3, 0x3, 0x2 with RS=0; each nibble is followed by CLR_WAIT_CYC.
REQ-018 S_INIT: SHALL then send bytes 0x28, 0x06, 0x0C, 0x01 with RS=0; 0x01 is followed by CLR_WAIT_CYC, the others by CMD_WAIT_CYC.
REQ-019 S_INIT: SHALL then go to S_IDLE.
REQ-020 Nibble strobe: LCDDAT/LCDRS are driven 2 cycles before LCDE rises; LCDE is held high EN_PW_CYC cycles; LCDDAT/LCDRS are held 2 cycles after LCDE falls.
REQ-021 Byte send: SHALL send the high nibble, wait NIB_GAP_CYC, send the low nibble, then apply the REQ-018 wait.
REQ-022 Refresh sequence, in order: command 0x80; 16 data bytes strdata[255:128] MSB byte first; command 0xC0; 16 data bytes strdata[127:0].
REQ-023 Refresh length: exactly 34 bytes; no clear command is sent.
REQ-024 S_LOAD: SHALL snapshot strdata into an internal 256-bit register; characters sent come only from the snapshot.
REQ-025 SHALL keep a sticky pending flag, set whenever cls=1 in any state.
REQ-026 From S_IDLE with pending=1: SHALL clear pending and enter S_LOAD on the next cycle.
REQ-027 cls during a refresh: SHALL cause exactly one further refresh after the current one; multiple pulses collapse into one.
REQ-028 cls during S_PWR/S_INIT: SHALL be held pending and serviced right after init.
REQ-029 busy SHALL be 0 only in S_IDLE with pending=0.
REQ-030 LCDE SHALL never be high for other than EN_PW_CYC consecutive cycles.
REQ-031 Cycle counter SHALL be wide enough for max(POWERUP_CYC, CLR_WAIT_CYC) with no wrap.

Reset
REQ-032 On rst=1 at a clock edge: state=S_PWR, counters=0, pending=0, LCDE=0, LCDRS=0, LCDRW=0, LCDDAT=0, busy=1.
REQ-033 rst mid-strobe or mid-refresh SHALL drop LCDE=0 in the same edge and restart the full init; a pre-reset request is lost.
REQ-034 Reset SHALL NOT clear the snapshot register; its contents are irrelevant until the next S_LOAD.

Verification (sim params: POWERUP_CYC=20, EN_PW_CYC=2, NIB_GAP_CYC=3, CMD_WAIT_CYC=5, CLR_WAIT_CYC=8)
REQ-035 rst, then run: nibble trace 3,3,3,2,2,8,0,6,0,C,0,1 with RS=0, then busy=0.
REQ-036 strdata="01234567 00 0123f01d01e01m01w01 ", one-cycle cls: bytes 0x80,"01234567 00 0123",0xC0,"f01d01e01m01w01 " in order; RS=1 only on the 32 characters.
REQ-037 Change strdata 1 cycle after S_LOAD: transmitted characters still match the snapshot.
REQ-038 Three cls pulses during a refresh: exactly two refreshes total, then busy=0.
REQ-039 Assert rst during the 10th data strobe: LCDE=0 next cycle; init restarts from S_PWR; no further data bytes.
REQ-040 cls during S_PWR: the refresh starts immediately after init completes.
